// File: rtl/hms_timer.sv
// hms_timer: hh:mm:ss BCD timer/stopwatch with a one-second prescaler.
//
// Parameters
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   HOUR_MAX  highest hour value, 1..99
//   WRAP      up-mode behaviour at HOUR_MAX:59:59 (1 = roll over, 0 = hold and stop)
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i, stop_i   begin/resume and pause pulses
//   clear_i           zero the digits and stop
//   mode_i            0 = count up, 1 = count down
//   load_i, load_val_i  preset the digits from BCD {h1,h0,m1,m0,s1,s0}
//   lap_i             snapshot the current digits into lap_digits_o
//   digits_o          current BCD time, s0 in [3:0]
//   lap_digits_o      last lap snapshot
//   running_o         counting enabled
//   tick_o            one-cycle pulse on every digit update
//   done_o            one-cycle pulse when a terminal value stops the count
//   load_err_o        one-cycle pulse when a load is rejected
module hms_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int HOUR_MAX = 99,
  parameter int WRAP     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        mode_i,
  input  logic        load_i,
  input  logic [23:0] load_val_i,
  input  logic        lap_i,
  output logic [23:0] digits_o,
  output logic [23:0] lap_digits_o,
  output logic        running_o,
  output logic        tick_o,
  output logic        done_o,
  output logic        load_err_o
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    HMAX    = 8'(HOUR_MAX);

  logic [23:0]   digits_q, digits_d;
  logic [23:0]   lap_q, lap_d;
  logic          run_q, run_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          lerr_q, lerr_d;
  logic [PW-1:0] ps_q, ps_d;

  // Current digit fields
  logic [3:0] s0, s1, m0, m1, h0, h1;
  assign {h1, h0, m1, m0, s1, s0} = digits_q;

  // Hour value as binary, for the HOUR_MAX comparisons
  logic [7:0] hrs;
  assign hrs = {1'b0, h1, 3'b000} + {3'b000, h1, 1'b0} + {4'b0000, h0};

  logic zero;
  assign zero = (digits_q == 24'h0);

  // Up-mode terminal; the "greater than" leg covers hours that are already
  // beyond the limit, which then get the same hold/wrap treatment.
  logic at_term;
  assign at_term = (hrs > HMAX) ||
                   ((hrs == HMAX) && (m1 == 4'd5) && (m0 == 4'd9) &&
                    (s1 == 4'd5) && (s0 == 4'd9));

  // Up-count carry chain
  logic c0, c1, c2, c3, c4;
  logic [23:0] up_val;
  assign c0 = (s0 == 4'd9);
  assign c1 = c0 & (s1 == 4'd5);
  assign c2 = c1 & (m0 == 4'd9);
  assign c3 = c2 & (m1 == 4'd5);
  assign c4 = c3 & (h0 == 4'd9);
  assign up_val = {
    c4 ? h1 + 4'd1 : h1,
    c3 ? (c4 ? 4'd0 : h0 + 4'd1) : h0,
    c2 ? (c3 ? 4'd0 : m1 + 4'd1) : m1,
    c1 ? (c2 ? 4'd0 : m0 + 4'd1) : m0,
    c0 ? (c1 ? 4'd0 : s1 + 4'd1) : s1,
    c0 ? 4'd0 : s0 + 4'd1
  };

  // Down-count borrow chain
  logic b0, b1, b2, b3, b4;
  logic [23:0] dn_val;
  assign b0 = (s0 == 4'd0);
  assign b1 = b0 & (s1 == 4'd0);
  assign b2 = b1 & (m0 == 4'd0);
  assign b3 = b2 & (m1 == 4'd0);
  assign b4 = b3 & (h0 == 4'd0);
  assign dn_val = {
    b4 ? h1 - 4'd1 : h1,
    b3 ? (b4 ? 4'd9 : h0 - 4'd1) : h0,
    b2 ? (b3 ? 4'd5 : m1 - 4'd1) : m1,
    b1 ? (b2 ? 4'd9 : m0 - 4'd1) : m0,
    b0 ? (b1 ? 4'd5 : s1 - 4'd1) : s1,
    b0 ? 4'd9 : s0 - 4'd1
  };

  // Preset validation
  logic [3:0] l0, l1, l2, l3, l4, l5;
  logic [7:0] lhrs;
  logic       load_ok;
  assign {l5, l4, l3, l2, l1, l0} = load_val_i;
  assign lhrs = {1'b0, l5, 3'b000} + {3'b000, l5, 1'b0} + {4'b0000, l4};
  assign load_ok = (l0 <= 4'd9) && (l1 <= 4'd5) && (l2 <= 4'd9) &&
                   (l3 <= 4'd5) && (l4 <= 4'd9) && (l5 <= 4'd9) &&
                   (lhrs <= HMAX);

  // The prescaler only advances in cycles where no control outranking start
  // is active; a start while already running leaves counting undisturbed.
  logic cnt_en;
  assign cnt_en = run_q & ~clear_i & ~load_i & ~stop_i;

  always_comb begin
    digits_d = digits_q;
    lap_d    = lap_i ? digits_q : lap_q;
    run_d    = run_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    lerr_d   = 1'b0;
    ps_d     = ps_q;

    if (clear_i) begin
      digits_d = 24'h0;
      run_d    = 1'b0;
      ps_d     = '0;
    end else if (load_i) begin
      if (load_ok) begin
        digits_d = load_val_i;
        ps_d     = '0;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (stop_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      if (!(mode_i && zero)) run_d = 1'b1;
    end

    if (cnt_en) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        if (!mode_i) begin
          if (at_term) begin
            if (WRAP != 0) begin
              digits_d = 24'h0;
              tick_d   = 1'b1;
            end else begin
              run_d  = 1'b0;
              done_d = 1'b1;
            end
          end else begin
            digits_d = up_val;
            tick_d   = 1'b1;
          end
        end else if (zero) begin
          // Running down from zero (mode flipped after starting at 0):
          // nothing to decrement, so terminate without a digit update.
          run_d  = 1'b0;
          done_d = 1'b1;
        end else begin
          digits_d = dn_val;
          tick_d   = 1'b1;
          if (dn_val == 24'h0) begin
            run_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digits_q <= 24'h0;
      lap_q    <= 24'h0;
      run_q    <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      lerr_q   <= 1'b0;
      ps_q     <= '0;
    end else begin
      digits_q <= digits_d;
      lap_q    <= lap_d;
      run_q    <= run_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      lerr_q   <= lerr_d;
      ps_q     <= ps_d;
    end
  end

  assign digits_o     = digits_q;
  assign lap_digits_o = lap_q;
  assign running_o    = run_q;
  assign tick_o       = tick_q;
  assign done_o       = done_q;
  assign load_err_o   = lerr_q;

endmodule
